// File: rtl/wave_measure_ctrl.sv
// wave_measure_ctrl
//   Runs the low-band wave analyzer through repeated measurement cycles:
//   clear the analyzer, let its sample path settle, watch an_freq until it
//   stays unchanged and nonzero, then capture freq/amp and present them over
//   valid/ready. A window timeout covers inputs with no zero crossings.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   start                 single-cycle pulse, starts a measurement from IDLE
//   continuous            level, restart after every handshake
//   an_freq, an_amp       analyzer outputs (zero-crossing count, amplitude)
//   an_reset              synchronous clear to the analyzer
//   meas_freq, meas_amp   captured result
//   meas_valid/meas_ready result handshake
//   timeout               result came from window expiry (meas_freq = 0)
//   busy                  high whenever not IDLE
module wave_measure_ctrl #(
  parameter int unsigned CLR_CYC    = 4,
  parameter int unsigned SETTLE_CYC = 16,
  parameter int unsigned STABLE_CYC = 1024,
  parameter int unsigned WINDOW_CYC = 4000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        continuous,
  input  logic [21:0] an_freq,
  input  logic [11:0] an_amp,
  output logic        an_reset,
  output logic [21:0] meas_freq,
  output logic [11:0] meas_amp,
  output logic        meas_valid,
  input  logic        meas_ready,
  output logic        timeout,
  output logic        busy
);

  localparam int CW = 23;
  localparam logic [CW-1:0] CLR_LAST    = CW'(CLR_CYC - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYC - 1);
  localparam logic [CW-1:0] WINDOW_LAST = CW'(WINDOW_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_SETTLE, S_MEASURE, S_PRESENT
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;       // phase counter for CLEAR / SETTLE
  logic [CW-1:0] win_q;       // cycles spent in MEASURE
  logic [CW-1:0] stab_q;      // consecutive matching cycles
  logic [21:0]   last_q;
  logic          an_reset_q;
  logic [21:0]   freq_q;
  logic [11:0]   amp_q;
  logic          valid_q;
  logic          timeout_q;
  logic          busy_q;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == '1) ? v : v + CW'(1);
  endfunction

  logic [CW-1:0] cnt_d, win_d, stab_d;
  logic          match;

  assign cnt_d  = sat_inc(cnt_q);
  assign win_d  = sat_inc(win_q);
  assign stab_d = sat_inc(stab_q);
  assign match  = (an_freq == last_q) && (an_freq != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      win_q      <= '0;
      stab_q     <= '0;
      last_q     <= '0;
      an_reset_q <= 1'b0;
      freq_q     <= '0;
      amp_q      <= '0;
      valid_q    <= 1'b0;
      timeout_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start || continuous) begin
            state_q    <= S_CLEAR;
            cnt_q      <= '0;
            an_reset_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        S_CLEAR: begin
          if (cnt_q == CLR_LAST) begin
            state_q    <= S_SETTLE;
            cnt_q      <= '0;
            an_reset_q <= 1'b0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_SETTLE: begin
          if (cnt_q == SETTLE_LAST) begin
            state_q <= S_MEASURE;
            cnt_q   <= '0;
            win_q   <= '0;
            stab_q  <= '0;
            last_q  <= an_freq;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_MEASURE: begin
          win_q <= win_d;
          if (match) begin
            stab_q <= stab_d;
          end else begin
            stab_q <= '0;
            last_q <= an_freq;
          end
          // Stability is tested first so it wins over a same-cycle expiry.
          if (match && (stab_q == STABLE_LAST)) begin
            state_q   <= S_PRESENT;
            freq_q    <= an_freq;
            amp_q     <= an_amp;
            timeout_q <= 1'b0;
            valid_q   <= 1'b1;
          end else if (win_q == WINDOW_LAST) begin
            state_q   <= S_PRESENT;
            freq_q    <= '0;
            amp_q     <= an_amp;
            timeout_q <= 1'b1;
            valid_q   <= 1'b1;
          end
        end
        S_PRESENT: begin
          if (valid_q && meas_ready) begin
            valid_q <= 1'b0;
            if (continuous) begin
              state_q    <= S_CLEAR;
              cnt_q      <= '0;
              an_reset_q <= 1'b1;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q    <= S_IDLE;
          an_reset_q <= 1'b0;
          valid_q    <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign an_reset   = an_reset_q;
  assign meas_freq  = freq_q;
  assign meas_amp   = amp_q;
  assign meas_valid = valid_q;
  assign timeout    = timeout_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_wave_measure_ctrl.sv
// Directed bench for wave_measure_ctrl with CLR=4, SETTLE=16, STABLE=8,
// WINDOW=200. Inputs change and outputs are sampled 1 time unit after each
// rising edge; "k" counts edges since the start/continuous request.
//   CLEAR occupies edges 1..4, SETTLE ends at edge 21 (MEASURE entry),
//   constant nonzero freq gives valid after edge 29, timeout after edge 221.
module tb_wave_measure_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, start, continuous, meas_ready;
  logic [21:0] an_freq;
  logic [11:0] an_amp;
  logic        an_reset, meas_valid, timeout, busy;
  logic [21:0] meas_freq;
  logic [11:0] meas_amp;

  int n_cmp = 0;
  int n_err = 0;

  wave_measure_ctrl #(
    .CLR_CYC(4), .SETTLE_CYC(16), .STABLE_CYC(8), .WINDOW_CYC(200)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous),
    .an_freq(an_freq), .an_amp(an_amp), .an_reset(an_reset),
    .meas_freq(meas_freq), .meas_amp(meas_amp), .meas_valid(meas_valid),
    .meas_ready(meas_ready), .timeout(timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; continuous = 1'b0; meas_ready = 1'b0;
    an_freq = '0; an_amp = '0;
    tick(); tick();
    n_cmp++; if (an_reset !== 1'b0) begin n_err++; $display("FAIL reset_an_reset got %b want 0", an_reset); end
    n_cmp++; if (meas_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", meas_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (timeout !== 1'b0) begin n_err++; $display("FAIL reset_timeout got %b want 0", timeout); end
    n_cmp++; if (meas_freq !== 22'd0 || meas_amp !== 12'd0) begin
      n_err++; $display("FAIL reset_data got %0d/%0d want 0/0", meas_freq, meas_amp); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_shot();
    int first_v = 0;
    int nrst = 0;
    start = 1'b1; an_freq = '0; an_amp = 12'd300;
    for (int k = 1; k <= 300; k++) begin
      tick();
      if (k == 1) start = 1'b0;
      if (an_reset) nrst++;
      if (meas_valid) begin first_v = k; break; end
      if (k >= 21) an_freq = (k - 20 > 50) ? 22'd50 : 22'(k - 20);
    end
    // freq first reads 50 at edge 71; eight further matching edges later -> 79
    n_cmp++; if (nrst != 4) begin n_err++; $display("FAIL single_an_reset_len got %0d want 4", nrst); end
    n_cmp++; if (first_v != 79) begin n_err++; $display("FAIL single_valid_edge got %0d want 79", first_v); end
    n_cmp++; if (meas_freq !== 22'd50) begin n_err++; $display("FAIL single_freq got %0d want 50", meas_freq); end
    n_cmp++; if (meas_amp !== 12'd300) begin n_err++; $display("FAIL single_amp got %0d want 300", meas_amp); end
    n_cmp++; if (timeout !== 1'b0) begin n_err++; $display("FAIL single_timeout got %b want 0", timeout); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy got %b want 1", busy); end
    meas_ready = 1'b1;
    tick();
    meas_ready = 1'b0;
    n_cmp++; if (meas_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL single_after_hs valid=%b busy=%b want 0/0", meas_valid, busy); end
    n_cmp++; if (meas_freq !== 22'd50) begin n_err++; $display("FAIL single_freq_hold got %0d want 50", meas_freq); end
  endtask

  task automatic test_timeout_and_hold();
    int first_v = 0;
    int bad = 0;
    start = 1'b1; an_freq = '0; an_amp = 12'd77;
    for (int k = 1; k <= 400; k++) begin
      tick();
      if (k == 1) start = 1'b0;
      if (meas_valid) begin first_v = k; break; end
    end
    n_cmp++; if (first_v != 221) begin n_err++; $display("FAIL timeout_valid_edge got %0d want 221", first_v); end
    n_cmp++; if (meas_freq !== 22'd0) begin n_err++; $display("FAIL timeout_freq got %0d want 0", meas_freq); end
    n_cmp++; if (timeout !== 1'b1) begin n_err++; $display("FAIL timeout_flag got %b want 1", timeout); end
    n_cmp++; if (meas_amp !== 12'd77) begin n_err++; $display("FAIL timeout_amp got %0d want 77", meas_amp); end
    // consumer stalls for 30 cycles while the analyzer keeps moving
    an_freq = 22'd123; an_amp = 12'd999;
    for (int c = 0; c < 30; c++) begin
      tick();
      an_freq = an_freq + 22'd1;
      if (meas_valid !== 1'b1 || meas_freq !== 22'd0 || meas_amp !== 12'd77 || timeout !== 1'b1) bad++;
    end
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL hold_stable got %0d bad cycles want 0", bad); end
    meas_ready = 1'b1;
    tick();
    meas_ready = 1'b0;
    n_cmp++; if (meas_valid !== 1'b0) begin n_err++; $display("FAIL hold_hs_valid got %b want 0", meas_valid); end
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (meas_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL hold_single_hs got %0d bad cycles want 0", bad); end
    n_cmp++; if (timeout !== 1'b1) begin n_err++; $display("FAIL hold_timeout_kept got %b want 1", timeout); end
  endtask

  task automatic test_back_to_back();
    int results = 0;
    int cyc = 0;
    int edges[3];
    continuous = 1'b1; meas_ready = 1'b1; an_freq = 22'd5; an_amp = 12'd40;
    while (results < 3 && cyc < 200) begin
      tick(); cyc++;
      if (meas_valid) begin
        edges[results] = cyc;
        results++;
        n_cmp++; if (meas_freq !== 22'd5) begin n_err++; $display("FAIL b2b_freq got %0d want 5", meas_freq); end
        if (results == 3) continuous = 1'b0;
        tick(); cyc++;
        if (results < 3) begin
          n_cmp++; if (an_reset !== 1'b1 || meas_valid !== 1'b0) begin
            n_err++; $display("FAIL b2b_restart an_reset=%b valid=%b want 1/0", an_reset, meas_valid); end
        end else begin
          n_cmp++; if (busy !== 1'b0 || an_reset !== 1'b0) begin
            n_err++; $display("FAIL b2b_stop busy=%b an_reset=%b want 0/0", busy, an_reset); end
        end
      end
    end
    meas_ready = 1'b0;
    n_cmp++; if (results != 3) begin n_err++; $display("FAIL b2b_count got %0d want 3", results); end
    else begin
      n_cmp++; if (edges[0] != 29 || edges[1] != 58 || edges[2] != 87) begin
        n_err++; $display("FAIL b2b_edges got %0d,%0d,%0d want 29,58,87", edges[0], edges[1], edges[2]); end
    end
  endtask

  task automatic test_reset_in_clear();
    int first_v = 0;
    start = 1'b1;
    tick(); start = 1'b0;
    n_cmp++; if (an_reset !== 1'b1) begin n_err++; $display("FAIL rclr_pre got %b want 1", an_reset); end
    tick();
    rst_n = 1'b0;
    tick();
    n_cmp++; if (an_reset !== 1'b0 || busy !== 1'b0 || meas_valid !== 1'b0) begin
      n_err++; $display("FAIL rclr_outputs an_reset=%b busy=%b valid=%b want 0/0/0", an_reset, busy, meas_valid); end
    n_cmp++; if (meas_freq !== 22'd0) begin n_err++; $display("FAIL rclr_freq got %0d want 0", meas_freq); end
    rst_n = 1'b1; start = 1'b1; an_freq = 22'd9; an_amp = 12'd11;
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (k == 1) start = 1'b0;
      if (meas_valid) begin first_v = k; break; end
    end
    n_cmp++; if (first_v != 29) begin n_err++; $display("FAIL rclr_rerun_edge got %0d want 29", first_v); end
    n_cmp++; if (meas_freq !== 22'd9 || meas_amp !== 12'd11) begin
      n_err++; $display("FAIL rclr_rerun_data got %0d/%0d want 9/11", meas_freq, meas_amp); end
    meas_ready = 1'b1;
    tick();
    meas_ready = 1'b0;
  endtask

  task automatic test_start_ignored();
    int results = 0;
    int first_v = 0;
    start = 1'b1; meas_ready = 1'b1; an_freq = 22'd7; an_amp = 12'd3;
    for (int k = 1; k <= 120; k++) begin
      tick();
      start = (k == 24);
      if (meas_valid) begin
        results++;
        if (first_v == 0) first_v = k;
      end
    end
    meas_ready = 1'b0;
    n_cmp++; if (results != 1) begin n_err++; $display("FAIL ign_count got %0d want 1", results); end
    n_cmp++; if (first_v != 29) begin n_err++; $display("FAIL ign_edge got %0d want 29", first_v); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ign_busy got %b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_single_shot();
    test_timeout_and_hold();
    test_back_to_back();
    test_reset_in_clear();
    test_start_ignored();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
